// File: rtl/silife_pkg.sv
// Shared definitions for the matrix scanner.
//
// Contents:
//   silife_scan_state_t  scanner FSM state encoding
//   ParityBits           extra serial bits emitted per row (1 with parity, else 0)
//
// Configuration macro: SILIFE_SCAN_PARITY_EN. When it is defined, each row is followed
// by one odd-parity bit.

package silife_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StParity,
    StDone
  } silife_scan_state_t;

`ifdef SILIFE_SCAN_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

endpackage

// File: rtl/silife_piso.sv
// Parallel-in, serial-out register for one matrix row.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   load          capture din and clear the bit counter
//   shift         advance the register by one cell and bump the bit counter
//   din           row data, cell x in bit x
//   dout          current cell (cell 0 is presented first)
//   bit_cnt       index of the cell currently on dout
//   last          dout holds the final cell of the row

module silife_piso #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            shift,
  input  logic [WIDTH-1:0] din,
  output logic            dout,
  output logic [CntW-1:0] bit_cnt,
  output logic            last
);

  logic [WIDTH-1:0] sreg_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= din;
      cnt_q  <= '0;
    end else if (shift) begin
      // Shift towards bit 0 so cells leave in ascending x order.
      sreg_q <= sreg_q >> 1;
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

  always_comb begin
    dout    = sreg_q[0];
    bit_cnt = cnt_q;
    last    = (cnt_q == CntW'(WIDTH - 1));
  end

endmodule

// File: rtl/silife_matrix_scanner.sv
// Scans a WIDTH x HEIGHT cell matrix row by row and streams it out one bit per
// valid/ready transfer, row 0 first, cell 0 first within each row.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset (aborts a frame at once)
//   start         request one full-frame scan; ignored while busy
//   busy          scan in progress (also high during the done cycle)
//   row_select2   row address to the matrix read port
//   cells2        combinational row data for row_select2, sampled once per row
//   ser_data      serial bit
//   ser_valid     ser_data is valid; held stable while ser_ready is low
//   ser_ready     sink accepts the bit this cycle
//   frame_first   current bit is row 0, cell 0
//   done          one-cycle pulse after the last bit of the frame is accepted
//
// Configuration macro: SILIFE_SCAN_PARITY_EN adds one odd-parity bit (~^ of the
// captured row) after each row's cells.

module silife_matrix_scanner
  import silife_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      busy,
  output logic [$clog2(HEIGHT)-1:0] row_select2,
  input  logic [WIDTH-1:0]          cells2,
  output logic                      ser_data,
  output logic                      ser_valid,
  input  logic                      ser_ready,
  output logic                      frame_first,
  output logic                      done
);

  localparam int unsigned RowW = $clog2(HEIGHT);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  silife_scan_state_t state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;

  logic            load;
  logic            shift;
  logic            piso_bit;
  logic            piso_last;
  logic [CntW-1:0] bit_cnt;
  logic            row_last;

  silife_piso #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_piso (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (cells2),
    .dout    (piso_bit),
    .bit_cnt (bit_cnt),
    .last    (piso_last)
  );

`ifdef SILIFE_SCAN_PARITY_EN
  logic parity_q;

  // Parity is taken from the same sample the shift register captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ~^cells2;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  assign row_last = (row_q == RowW'(HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        load    = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        if (ser_ready) begin
          shift = 1'b1;
          if (piso_last) begin
            if (ParityBits != 0) begin
              state_d = StParity;
            end else if (row_last) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + RowW'(1);
              state_d = StLoad;
            end
          end
        end
      end
      StParity: begin
        if (ser_ready) begin
          if (row_last) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + RowW'(1);
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        // No queued restart: start seen here is dropped.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    row_select2 = row_q;
    ser_valid   = (state_q == StShift) || (state_q == StParity);
    ser_data    = 1'b0;
    if (state_q == StShift) begin
      ser_data = piso_bit;
    end else if (state_q == StParity) begin
`ifdef SILIFE_SCAN_PARITY_EN
      ser_data = parity_q;
`else
      ser_data = 1'b0;
`endif
    end
    frame_first = (state_q == StShift) && (row_q == '0) && (bit_cnt == '0);
  end

endmodule

// File: tb/tb_silife_matrix_scanner.sv
// Self-checking bench for silife_matrix_scanner: directed scenarios plus randomized
// matrices and ready patterns, checked against a frame model built from row values.

module tb_silife_matrix_scanner;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int RW = $clog2(H);
`ifdef SILIFE_SCAN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FB  = H * (W + P);
  localparam int LAT = 1 + H * (1 + W + P) + 1;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          busy;
  logic [RW-1:0] row_select2;
  logic [W-1:0]  cells2;
  logic          ser_data;
  logic          ser_valid;
  logic          ser_ready;
  logic          frame_first;
  logic          done;

  logic [W-1:0] mem      [H];
  logic [W-1:0] exp_rows [H];
  int           ready_mode;
  logic         mon_clr;

  int n_chk = 0;
  int n_bad = 0;

  logic [127:0] mon_bits;
  int mon_n, mon_ff_cnt, mon_ff_idx, mon_ff_stray, mon_done_cnt, mon_lat;
  int mon_stall_seen, mon_stall_bad, mon_busy_at_done;
  int cyc, t0;

  assign cells2 = mem[row_select2];

  silife_matrix_scanner #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .busy        (busy),
    .row_select2 (row_select2),
    .cells2      (cells2),
    .ser_data    (ser_data),
    .ser_valid   (ser_valid),
    .ser_ready   (ser_ready),
    .frame_first (frame_first),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sink ready pattern: 0 = always ready, 1 = repeating 1,0,0, 2 = random.
  initial begin
    int p;
    p = 0;
    ser_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       ser_ready = (p % 3 == 0);
        2:       ser_ready = 1'($urandom_range(0, 1));
        default: ser_ready = 1'b1;
      endcase
      p++;
    end
  end

  // Observer, sampling between edges.
  initial begin
    logic prev_stall;
    logic prev_data;
    cyc = 0;
    t0 = 0;
    prev_stall = 1'b0;
    prev_data = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_clr) begin
        mon_bits = '0;
        mon_n = 0;
        mon_ff_cnt = 0;
        mon_ff_idx = -1;
        mon_ff_stray = 0;
        mon_done_cnt = 0;
        mon_lat = 0;
        mon_stall_seen = 0;
        mon_stall_bad = 0;
        mon_busy_at_done = 0;
        prev_stall = 1'b0;
      end else begin
        if (start && !busy && reset_n) t0 = cyc;
        if (prev_stall) begin
          mon_stall_seen++;
          if (!ser_valid || ser_data !== prev_data) mon_stall_bad++;
        end
        if (ser_valid && ser_ready) begin
          if (mon_n < 128) mon_bits[mon_n] = ser_data;
          if (frame_first) begin
            mon_ff_cnt++;
            mon_ff_idx = mon_n;
          end
          mon_n++;
        end
        if (frame_first && !ser_valid) mon_ff_stray++;
        prev_stall = ser_valid && !ser_ready;
        prev_data = ser_data;
        if (done) begin
          mon_done_cnt++;
          mon_lat = cyc - t0 + 1;
          mon_busy_at_done = int'(busy);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Expected serial frame: rows in order, cells LSB first, optional odd parity per row.
  function automatic logic [127:0] exp_frame();
    logic [127:0] v;
    int i;
    v = '0;
    i = 0;
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W; x++) begin
        v[i] = exp_rows[r][x];
        i++;
      end
      if (P == 1) begin
        v[i] = ~^exp_rows[r];
        i++;
      end
    end
    return v;
  endfunction

  task automatic randomize_mem();
    for (int r = 0; r < H; r++) mem[r] = W'($urandom);
  endtask

  task automatic run_frame(input int mode, input bit extra, input bit mod_rows);
    bit got_done;
    got_done = 1'b0;
    ready_mode = mode;
    clear_mon();
    for (int r = 0; r < H; r++) exp_rows[r] = mem[r];
    @(posedge clk);
    #1 start = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      start = extra && (k == 4 || k == 39);
      if (extra && done) start = 1'b1;
      if (k == 0) check_val("busy_after_start", 128'(busy), 128'(1));
      if (mod_rows && k == 20) begin
        // Row 2 is mid-shift, row 3 not yet sampled.
        mem[3] = ~mem[3] ^ 8'h5A;
        exp_rows[3] = mem[3];
        mem[2] = ~mem[2];
      end
      if (mon_done_cnt > 0 && !done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check_val("done_seen", 128'(got_done), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    check_val("idle_after_frame", 128'({busy, done}), 128'(0));
  endtask

  task automatic check_frame(input string tag, input bit chk_lat);
    check_val({tag, "_len"}, 128'(mon_n), 128'(FB));
    check_val({tag, "_bits"}, mon_bits, exp_frame());
    check_val({tag, "_first"}, {32'(mon_ff_cnt), 32'(mon_ff_idx), 32'(mon_ff_stray)},
              {32'd1, 32'd0, 32'd0});
    check_val({tag, "_done"}, {32'(mon_done_cnt), 32'(mon_busy_at_done)}, {32'd1, 32'd1});
    check_val({tag, "_stall"}, 128'(mon_stall_bad), 128'(0));
    if (chk_lat) check_val({tag, "_latency"}, 128'(mon_lat), 128'(LAT));
  endtask

  initial begin
    logic [127:0] ref_bits;
    ready_mode = 0;
    mon_clr = 1'b0;
    start = 1'b0;
    reset_n = 1'b0;
    for (int r = 0; r < H; r++) mem[r] = W'(1) << r;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs",
              128'({busy, ser_valid, ser_data, frame_first, done, row_select2}), 128'(0));
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Diagonal matrix, always ready.
    run_frame(0, 1'b0, 1'b0);
    check_frame("diag", 1'b1);
    ref_bits = mon_bits;
`ifndef SILIFE_SCAN_PARITY_EN
    check_val("diag_pattern", 128'(mon_bits[63:0]), 128'(64'h8040_2010_0804_0201));
`endif

    // Same matrix with stalls: identical stream.
    run_frame(1, 1'b0, 1'b0);
    check_frame("stall", 1'b0);
    check_val("stall_vs_ready", mon_bits, ref_bits);
    check_val("stall_occurred", 128'(mon_stall_seen > 0), 128'(1));

    // Extra starts mid-frame and during done are dropped.
    randomize_mem();
    run_frame(0, 1'b1, 1'b0);
    check_frame("restart_ignored", 1'b1);

    // Row data changes around the sampling point.
    randomize_mem();
    run_frame(0, 1'b0, 1'b1);
    check_frame("row_change", 1'b1);

    // Reset during row 4, bit 2.
    randomize_mem();
    ready_mode = 0;
    clear_mon();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check_val("pre_reset_pos", 128'({busy, ser_valid, ser_data, row_select2}),
              128'({1'b1, 1'b1, mem[4][2], RW'(4)}));
    #1 reset_n = 1'b0;
    #1;
    check_val("async_reset_outputs",
              128'({busy, ser_valid, ser_data, frame_first, done, row_select2}), 128'(0));
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("abort_no_done", 128'(mon_done_cnt), 128'(0));
    check_val("abort_waits_start", 128'(busy), 128'(0));
    run_frame(0, 1'b0, 1'b0);
    check_frame("post_reset", 1'b1);

`ifdef SILIFE_SCAN_PARITY_EN
    for (int r = 0; r < H; r++) mem[r] = (r % 2 == 0) ? 8'hFF : 8'h07;
    run_frame(0, 1'b0, 1'b0);
    check_frame("parity", 1'b1);
    check_val("parity_ff", 128'(mon_bits[8]), 128'(1));
    check_val("parity_07", 128'(mon_bits[17]), 128'(0));
`endif

    // Randomized matrices and sink behaviour.
    for (int n = 0; n < 6; n++) begin
      randomize_mem();
      run_frame((n % 2 == 0) ? 2 : 1, 1'b0, 1'b0);
      check_frame("random", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/silife_matrix_scanner.md
SILIFE_MATRIX_SCANNER -- requirements
Module: silife_matrix_scanner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning cells per matrix row.
REQ-002 The block SHALL have parameter HEIGHT, default 8, meaning rows in the matrix.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning reset; reset is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, meaning a request to scan one full frame.
REQ-006 The block SHALL have port busy, output, 1, meaning a scan is in progress; the top level gates the matrix enable with it.
REQ-007 The block SHALL have port row_select2, output, $clog2(HEIGHT), meaning the row address to the matrix read-only port.
REQ-008 The block SHALL have port cells2, input, WIDTH, meaning the combinational row data returned for row_select2.
REQ-009 The block SHALL have port ser_data, output, 1, meaning the current serial bit.
REQ-010 The block SHALL have port ser_valid, output, 1, meaning ser_data is valid.
REQ-011 The block SHALL have port ser_ready, input, 1, meaning the sink accepts a bit; a bit transfers on a cycle with ser_valid && ser_ready.
REQ-012 The block SHALL have port frame_first, output, 1, meaning the current bit is the first bit of the frame (row 0, cell 0).
REQ-013 The block SHALL have port done, output, 1, meaning a one-cycle pulse after the last bit of the frame is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT, PARITY and DONE.
REQ-015 In IDLE, start=1 SHALL clear the row counter and move the FSM to LOAD; busy SHALL assert in the following cycle.
REQ-016 In LOAD, row_select2 SHALL equal the row counter, and cells2 SHALL be captured into a WIDTH-bit shift register at the cycle end, followed by a move to SHIFT.
REQ-017 In SHIFT, ser_valid SHALL be 1, and ser_data SHALL be the shift register bit holding cell x, sent in x = 0 first.
REQ-018 Each transfer SHALL advance the shift register and the bit counter.
REQ-019 ser_data and ser_valid SHALL stay stable while ser_ready=0.
REQ-020 After the WIDTH-th transfer, the FSM SHALL go to PARITY when the parity feature is compiled in; otherwise it SHALL take the end-of-row transition.
REQ-021 End-of-row transition: if row = HEIGHT-1, go to DONE; otherwise increment the row and go to LOAD.
REQ-022 The row counter SHALL never wrap past HEIGHT-1.
REQ-023 In DONE, done=1 for exactly one cycle, busy SHALL remain 1, and the FSM SHALL then return to IDLE.
REQ-024 start SHALL be ignored while busy=1 and in DONE; there is no queued restart.
REQ-025 frame_first SHALL be 1 only while the SHIFT state holds row 0, bit 0.
REQ-026 Each row SHALL be sampled once, in its LOAD cycle; later changes to cells2 SHALL not alter bits already captured.
REQ-027 Minimum frame latency with ser_ready held 1 SHALL be 1 + HEIGHT*(1+WIDTH+P) + 1 cycles from start to done, where P = 1 with parity, else 0.

Reset
REQ-028 While reset_n=0, the FSM SHALL be IDLE, the row and bit counters 0, the shift register 0, and row_select2, ser_data, ser_valid, busy, frame_first and done all 0.
REQ-029 Assertion of reset_n mid-frame SHALL abort the frame immediately and asynchronously, with no done pulse.
REQ-030 After release of reset_n, the block SHALL wait for a new start.

Configuration
REQ-031 With SILIFE_SCAN_PARITY_EN defined, the PARITY state SHALL emit one extra bit per row after the cells, equal to odd parity (~^ of the captured row), using the same valid/ready handshake.
REQ-032 Without SILIFE_SCAN_PARITY_EN, the PARITY state SHALL be unreachable and each row SHALL be exactly WIDTH bits.

Structure
REQ-033 A shared package silife_pkg SHALL hold the FSM state enum silife_scan_state_t and the parity bit-count constant.
REQ-034 One sub-module, silife_piso, SHALL hold the WIDTH-bit load/shift register with its bit counter; the FSM and row counter SHALL stay in the top module.

Verification
REQ-035 Scenario: 8x8, no parity, ser_ready=1, row r = 8'h01<<r, single start -> 64 bits equal to a diagonal, frame_first on bit 0 only, done at cycle 74.
REQ-036 Scenario: ser_ready toggling 1,0,0 repeatedly -> ser_data and ser_valid are stable through stalls and the bitstream is identical to the ready=1 run.
REQ-037 Scenario: start pulsed again at cycles 5 and 40 of a frame -> ignored; exactly one done pulse occurs.
REQ-038 Scenario: cells2 changed for row 3 while row 2 is shifting -> the new row-3 value is emitted; cells2 changed for row 2 mid-row -> no effect on row 2.
REQ-039 Scenario: reset_n low during row 4 bit 2 -> all outputs 0 asynchronously, no done pulse; the next start emits from row 0.
REQ-040 Scenario: SILIFE_SCAN_PARITY_EN with row = 8'hFF, then 8'h07 -> parity bits 1, then 0; frame length 72 bits.
